// File: rtl/axis_spi_periph.sv
// SPI peripheral endpoint: synchronises sclk/csn/mosi into clk, deserialises
// MOSI words onto AXI-Stream RX and serialises AXI-Stream TX words onto MISO.
// Ports: clk/rst (sync, active high); cfg_transfer_zsz/cfg_spi_mode latched
// at frame start; axis_tx_* (word source for MISO), axis_rx_* (received
// words, last = final word before csn rise); stat_* one-cycle event pulses;
// spi_sclk/spi_csn/spi_mosi from the master, spi_miso/spi_miso_oe to it.
module axis_spi_periph #(
  parameter int         DATA_WIDTH  = 32,
  parameter int         DATA_WBITS  = $clog2(DATA_WIDTH),
  parameter int         SYNC_STAGES = 2,
  parameter logic [0:0] MISO_IDLE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WBITS-1:0] cfg_transfer_zsz,
  input  logic [1:0]            cfg_spi_mode,
  input  logic                  axis_tx_valid,
  output logic                  axis_tx_ready,
  input  logic [DATA_WIDTH-1:0] axis_tx_data,
  output logic                  axis_rx_valid,
  input  logic                  axis_rx_ready,
  output logic [DATA_WIDTH-1:0] axis_rx_data,
  output logic                  axis_rx_last,
  output logic                  stat_overrun,
  output logic                  stat_underrun,
  output logic                  stat_abort,
  input  logic                  spi_sclk,
  input  logic                  spi_csn,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe
);
  localparam int S = SYNC_STAGES;

  // sclk/csn carry one extra stage so edges compare current vs previous
  logic [S:0]   r_sclk_s;
  logic [S:0]   r_csn_s;
  logic [S-1:0] r_mosi_s;
  // After reset a frame already in progress must not look like a new one:
  // r_armed only sets once csn has really been seen high since reset.
  logic         r_flush;
  logic         r_armed;

  logic                  r_samp_rise;
  logic                  r_drive;
  logic [DATA_WBITS-1:0] r_zsz;
  logic [DATA_WBITS-1:0] r_cnt;
  logic [DATA_WBITS-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic                  r_pend;
  logic                  r_oe;
  logic                  r_miso;
  logic                  r_tx_ready;
  logic                  r_rx_valid;
  logic                  r_rx_last;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_overrun;
  logic                  r_underrun;
  logic                  r_abort;

  logic                  w_sclk;
  logic                  w_sclk_q;
  logic                  w_csn;
  logic                  w_csn_q;
  logic                  w_mosi;
  logic                  w_csn_fall;
  logic                  w_csn_rise;
  logic                  w_edge_ok;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_sample;
  logic                  w_shift;
  logic                  w_done;
  logic                  w_load;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_rx_next;

  assign w_sclk   = r_sclk_s[S-1];
  assign w_sclk_q = r_sclk_s[S];
  assign w_csn    = r_csn_s[S-1];
  assign w_csn_q  = r_csn_s[S];
  assign w_mosi   = r_mosi_s[S-1];

  assign w_csn_fall = r_armed & ~r_oe & w_csn_q & ~w_csn;
  assign w_csn_rise = r_oe & ~w_csn_q & w_csn;
  // A csn rise has w_csn high, so a coincident sclk edge is dropped here
  assign w_edge_ok  = r_oe & ~w_csn;
  assign w_rise     = ~w_sclk_q & w_sclk;
  assign w_fall     = w_sclk_q & ~w_sclk;
  assign w_sample   = w_edge_ok & (r_samp_rise ? w_rise : w_fall);
  assign w_shift    = w_edge_ok & (r_samp_rise ? w_fall : w_rise);
  assign w_done     = (r_cnt == r_zsz);
  assign w_load     = w_csn_fall | (w_sample & w_done);
  assign w_push     = r_pend & (w_csn_rise | w_sample);
  assign w_rx_next  = {r_rx_sh[DATA_WIDTH-2:0], w_mosi};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s <= '0;
      r_csn_s  <= '1;
      r_mosi_s <= '0;
      r_flush  <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[S-1:0], spi_sclk};
      r_csn_s  <= {r_csn_s[S-1:0], spi_csn};
      r_mosi_s <= {r_mosi_s[S-2:0], spi_mosi};
      r_flush  <= 1'b1;
      if (r_flush && r_csn_s[0]) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp_rise <= 1'b1;
      r_drive     <= 1'b0;
      r_zsz       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_pend_data <= '0;
      r_pend      <= 1'b0;
      r_oe        <= 1'b0;
      r_miso      <= MISO_IDLE;
      r_tx_ready  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_last   <= 1'b0;
      r_rx_data   <= '0;
      r_overrun   <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_drive    <= 1'b0;
      if (r_rx_valid && axis_rx_ready) r_rx_valid <= 1'b0;

      // CPHA=0 puts the first MSB out one cycle after the frame starts
      if (r_drive) begin
        r_miso <= r_tx_sh[r_idx];
        r_idx  <= r_idx - 1'b1;
      end

      if (w_csn_fall) begin
        r_zsz       <= cfg_transfer_zsz;
        r_samp_rise <= (cfg_spi_mode[1] == cfg_spi_mode[0]);
        r_drive     <= ~cfg_spi_mode[0];
        r_idx       <= cfg_transfer_zsz;
        r_cnt       <= '0;
        r_rx_sh     <= '0;
        r_pend      <= 1'b0;
        r_oe        <= 1'b1;
      end else if (w_csn_rise) begin
        r_oe    <= 1'b0;
        r_miso  <= MISO_IDLE;
        r_abort <= (r_cnt != '0);
        r_cnt   <= '0;
        r_rx_sh <= '0;
        r_pend  <= 1'b0;
      end else if (w_sample) begin
        r_pend <= w_done;
        if (w_done) begin
          r_pend_data <= w_rx_next;
          r_rx_sh     <= '0;
          r_cnt       <= '0;
          r_idx       <= r_zsz;
        end else begin
          r_rx_sh <= w_rx_next;
          r_cnt   <= r_cnt + 1'b1;
        end
      end else if (w_shift) begin
        r_miso <= r_tx_sh[r_idx];
        r_idx  <= r_idx - 1'b1;
      end

      if (w_load) begin
        if (axis_tx_valid) begin
          r_tx_ready <= 1'b1;
          r_tx_sh    <= axis_tx_data;
        end else begin
          r_underrun <= 1'b1;
          r_tx_sh    <= {DATA_WIDTH{MISO_IDLE}};
        end
      end

      // A full RX slot that is not being drained keeps its word
      if (w_push) begin
        if (!r_rx_valid || axis_rx_ready) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_pend_data;
          r_rx_last  <= w_csn_rise;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign axis_tx_ready = r_tx_ready;
  assign axis_rx_valid = r_rx_valid;
  assign axis_rx_data  = r_rx_data;
  assign axis_rx_last  = r_rx_last;
  assign stat_overrun  = r_overrun;
  assign stat_underrun = r_underrun;
  assign stat_abort    = r_abort;
  assign spi_miso      = r_miso;
  assign spi_miso_oe   = r_oe;
endmodule

// File: tb/tb_axis_spi_periph.sv
// Bench for axis_spi_periph: a behavioural SPI master plus a word-level model
// of what the peripheral must return on RX, MISO and its status pulses.
module tb_axis_spi_periph;
  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cfg_transfer_zsz = '0;
  logic [1:0]  cfg_spi_mode = '0;
  logic        axis_tx_valid = 1'b0;
  logic        axis_tx_ready;
  logic [31:0] axis_tx_data = '0;
  logic        axis_rx_valid;
  logic        axis_rx_ready = 1'b1;
  logic [31:0] axis_rx_data;
  logic        axis_rx_last;
  logic        stat_overrun;
  logic        stat_underrun;
  logic        stat_abort;
  logic        spi_sclk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;

  axis_spi_periph dut (
    .clk(clk), .rst(rst),
    .cfg_transfer_zsz(cfg_transfer_zsz), .cfg_spi_mode(cfg_spi_mode),
    .axis_tx_valid(axis_tx_valid), .axis_tx_ready(axis_tx_ready),
    .axis_tx_data(axis_tx_data),
    .axis_rx_valid(axis_rx_valid), .axis_rx_ready(axis_rx_ready),
    .axis_rx_data(axis_rx_data), .axis_rx_last(axis_rx_last),
    .stat_overrun(stat_overrun), .stat_underrun(stat_underrun),
    .stat_abort(stat_abort),
    .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rdy, n_under, n_over, n_abort, n_unstable;
  logic        oe_seen;
  logic [31:0] tx_q[$];
  logic [32:0] rx_got[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX source and event monitor, sampled away from the active edge
  initial forever begin
    @(negedge clk);
    if (axis_tx_ready) begin
      n_rdy++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (stat_underrun) n_under++;
    if (stat_overrun) n_over++;
    if (stat_abort) n_abort++;
    if (axis_rx_valid && axis_rx_ready)
      rx_got.push_back({axis_rx_last, axis_rx_data});
    axis_tx_valid = (tx_q.size() > 0);
    axis_tx_data  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
  end

  task automatic clr_stats();
    n_rdy = 0; n_under = 0; n_over = 0; n_abort = 0;
    n_unstable = 0; rx_got = {};
  endtask

  // SPI master: clocks nbits MSB-first from mw, returns MISO grouped by word
  task automatic spi_xfer(input logic [1:0] mode, input int zsz,
                          input logic [31:0] mw[$], input int nbits,
                          input int rst_at, output logic [31:0] mg[$]);
    int          w;
    logic        ms, b;
    logic [31:0] cur, acc;
    w = zsz + 1;
    mg = {};
    acc = '0;
    ms = 1'b0;
    cfg_spi_mode = mode;
    cfg_transfer_zsz = 5'(zsz);
    spi_sclk = mode[1];
    wait_clk(HP);
    spi_csn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
      end
      cur = mw[i / w];
      b = cur[zsz - (i % w)];
      if (!mode[0]) begin
        spi_mosi = b;
        wait_clk(HP);
        ms = spi_miso;
        if (i == 0) oe_seen = spi_miso_oe;
        spi_sclk = ~spi_sclk;
        wait_clk(HP);
        if (spi_miso !== ms) n_unstable++;
        spi_sclk = ~spi_sclk;
      end else begin
        wait_clk(HP);
        if (i > 0 && spi_miso !== ms) n_unstable++;
        spi_sclk = ~spi_sclk;
        spi_mosi = b;
        wait_clk(HP);
        ms = spi_miso;
        if (i == 0) oe_seen = spi_miso_oe;
        spi_sclk = ~spi_sclk;
      end
      acc = {acc[30:0], ms};
      if ((i % w) == zsz) begin
        mg.push_back(acc);
        acc = '0;
      end
    end
    if ((nbits % w) != 0) mg.push_back(acc);
    wait_clk(HP);
    spi_csn = 1'b1;
    wait_clk(4 * HP);
  endtask

  // One frame against the word-level model: each complete word appears on
  // RX, the last one flagged only if no partial word follows; word k on
  // MISO is the k-th offered TX word or all ones; one TX load per frame
  // start and per completed word.
  task automatic do_frame(input string tag, input logic [1:0] mode,
                          input int zsz, input logic [31:0] mw[$],
                          input int nbits, input logic [31:0] txw[$]);
    int          w, nfull, rem, loads, exp_rdy;
    logic [31:0] mask, full, exp;
    logic [31:0] mg[$];
    w = zsz + 1;
    nfull = nbits / w;
    rem = nbits % w;
    mask = 32'((64'd1 << w) - 64'd1);
    tx_q = txw;
    wait_clk(4);
    clr_stats();
    oe_seen = 1'b0;
    spi_xfer(mode, zsz, mw, nbits, -1, mg);
    check({tag, " rx_count"}, rx_got.size(), nfull);
    for (int k = 0; k < nfull && k < rx_got.size(); k++)
      check({tag, " rx_word"}, rx_got[k],
            {(k == nfull - 1) && (rem == 0), mw[k] & mask});
    for (int k = 0; k < mg.size(); k++) begin
      full = (k < txw.size()) ? (txw[k] & mask) : mask;
      exp = (k < nfull) ? full : (full >> (w - rem));
      check({tag, " miso_word"}, mg[k], exp);
    end
    loads = 1 + nfull;
    exp_rdy = (loads < txw.size()) ? loads : txw.size();
    check({tag, " tx_ready_n"}, n_rdy, exp_rdy);
    check({tag, " underrun_n"}, n_under, loads - exp_rdy);
    check({tag, " abort_n"}, n_abort, (rem != 0) ? 1 : 0);
    check({tag, " overrun_n"}, n_over, 0);
    check({tag, " miso_stable"}, n_unstable, 0);
    check({tag, " oe_active"}, oe_seen, 1'b1);
    check({tag, " idle_after"}, {spi_miso_oe, spi_miso, axis_rx_valid},
          3'b010);
  endtask

  logic [31:0] mw[$];
  logic [31:0] txw[$];
  logic [31:0] mg[$];

  initial begin
    logic [1:0] mode;
    int         zsz, nw, nt, nbits;
    clr_stats();
    wait_clk(5);
    check("reset_rx", {axis_rx_valid, axis_rx_last, axis_rx_data}, 34'h0);
    check("reset_stat", {axis_tx_ready, stat_overrun, stat_underrun,
                         stat_abort}, 4'h0);
    check("reset_miso", {spi_miso_oe, spi_miso}, 2'b01);
    rst = 1'b0;
    wait_clk(10);

    mw = {32'hA5}; txw = {32'h3C, 32'h99};
    do_frame("mode0_a5", 2'd0, 7, mw, 8, txw);

    mw = {32'h1234, 32'hBEEF, 32'h0001};
    txw = {32'hCAFE, 32'h5555, 32'h0F0F, 32'h1111};
    do_frame("mode3_x3", 2'd3, 15, mw, 48, txw);

    mw = {32'hDEADBEEF}; txw = {$urandom, $urandom};
    do_frame("mode1_32", 2'd1, 31, mw, 32, txw);
    txw = {$urandom, $urandom};
    do_frame("mode2_32", 2'd2, 31, mw, 32, txw);

    mw = {32'hA5}; txw = {};
    do_frame("underrun_abort", 2'd0, 7, mw, 5, txw);

    axis_rx_ready = 1'b0;
    tx_q = {32'h01, 32'h02};
    wait_clk(4);
    clr_stats();
    mw = {32'h11};
    spi_xfer(2'd0, 7, mw, 8, -1, mg);
    tx_q = {32'h03, 32'h04};
    wait_clk(4);
    mw = {32'h22};
    spi_xfer(2'd0, 7, mw, 8, -1, mg);
    check("ovr_valid", axis_rx_valid, 1'b1);
    check("ovr_hold", {axis_rx_last, axis_rx_data}, {1'b1, 32'h11});
    check("ovr_pulses", n_over, 1);
    axis_rx_ready = 1'b1;
    wait_clk(4 * HP);
    check("ovr_drain_n", rx_got.size(), 1);
    if (rx_got.size() > 0) check("ovr_drain", rx_got[0], {1'b1, 32'h11});
    check("ovr_clear", axis_rx_valid, 1'b0);

    tx_q = {32'h77, 32'h78};
    wait_clk(4);
    clr_stats();
    mw = {32'h96};
    spi_xfer(2'd0, 7, mw, 8, 4, mg);
    check("rst_mid_rx", rx_got.size(), 0);
    check("rst_mid_state", {axis_rx_valid, spi_miso_oe, n_over[0],
                            n_abort[0]}, 4'h0);
    mw = {32'h5A}; txw = {32'h3C, 32'hC3};
    do_frame("after_rst", 2'd0, 7, mw, 8, txw);

    for (int f = 0; f < 12; f++) begin
      mode = 2'($urandom_range(0, 3));
      zsz = $urandom_range(0, 31);
      nw = $urandom_range(1, 3);
      nt = $urandom_range(0, nw + 1);
      mw = {};
      txw = {};
      for (int k = 0; k < nw; k++) mw.push_back($urandom);
      for (int k = 0; k < nt; k++) txw.push_back($urandom);
      nbits = nw * (zsz + 1);
      if (zsz > 0 && $urandom_range(0, 3) == 0)
        nbits = nbits - $urandom_range(1, zsz);
      do_frame($sformatf("rand%0d_m%0d_z%0d", f, mode, zsz),
               mode, zsz, mw, nbits, txw);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
